// File: rtl/fetch_stage.sv
// Instruction-fetch stage: boots the PC from imem words 0/1, fetches one- and two-word
// instructions, applies redirects/stalls/clears and loads the IF/ID register.
module fetch_stage #(
    parameter int          IMEM_AW   = 20,
    parameter logic [15:0] NOP_INSTR = 16'h4000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [15:0]        imem_rdata,
    input  logic               pc_write,
    input  logic               clear_instruction,
    input  logic               jump_taken,
    input  logic [31:0]        jump_target,
    input  logic               pc_choose_memory,
    input  logic [31:0]        mem_pc,
    output logic [15:0]        if_instruction,
    output logic [15:0]        if_immediate,
    output logic [31:0]        if_pc,
    output logic [31:0]        if_pc_next,
    output logic               if_valid
);

    typedef enum logic [1:0] {BOOT_HI, BOOT_LO, RUN, IMM} state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, imm: 16'h0, pc: 32'h0, pc_next: 32'h0, valid: 1'b0};

    state_t      state, state_n;
    logic [31:0] pc, pc_n, pc_inc;
    logic [15:0] boot_hi, boot_hi_n;
    logic [15:0] hold_instr, hold_instr_n;
    logic [31:0] hold_pc, hold_pc_n;
    ifid_t       ifid, ifid_n;
    logic        two_word;

    assign pc_inc   = pc + 32'd1;
    assign two_word = (imem_rdata[15:11] == 5'b10001) ||
                      (imem_rdata[15:11] == 5'b10100) ||
                      (imem_rdata[15:11] == 5'b10101);

    always_comb begin
        case (state)
            BOOT_HI: imem_addr = '0;
            BOOT_LO: imem_addr = IMEM_AW'(1);
            default: imem_addr = pc[IMEM_AW-1:0];
        endcase
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        boot_hi_n    = boot_hi;
        hold_instr_n = hold_instr;
        hold_pc_n    = hold_pc;
        ifid_n       = ifid;
        case (state)
            BOOT_HI: begin
                boot_hi_n = imem_rdata;
                ifid_n    = BUBBLE;
                state_n   = BOOT_LO;
            end
            BOOT_LO: begin
                pc_n    = {boot_hi, imem_rdata};
                ifid_n  = BUBBLE;
                state_n = RUN;
            end
            default: begin
                // Redirects beat a stall; any half-assembled two-word op is dropped.
                if (pc_choose_memory || jump_taken) begin
                    pc_n         = pc_choose_memory ? mem_pc : jump_target;
                    ifid_n       = BUBBLE;
                    hold_instr_n = '0;
                    hold_pc_n    = '0;
                    state_n      = RUN;
                end else if (pc_write) begin
                    pc_n = pc_inc;
                    if (state == IMM) begin
                        ifid_n  = '{instr: hold_instr, imm: imem_rdata, pc: hold_pc,
                                    pc_next: pc_inc, valid: 1'b1};
                        state_n = RUN;
                    end else if (two_word) begin
                        hold_instr_n = imem_rdata;
                        hold_pc_n    = pc;
                        ifid_n       = BUBBLE;
                        state_n      = IMM;
                    end else begin
                        ifid_n = '{instr: imem_rdata, imm: 16'h0, pc: pc,
                                   pc_next: pc_inc, valid: 1'b1};
                    end
                    // Clear only squashes the IF/ID load; PC and FSM still advance.
                    if (clear_instruction)
                        ifid_n = BUBBLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= BOOT_HI;
            pc         <= '0;
            boot_hi    <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
            ifid       <= BUBBLE;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            boot_hi    <= boot_hi_n;
            hold_instr <= hold_instr_n;
            hold_pc    <= hold_pc_n;
            ifid       <= ifid_n;
        end
    end

    assign if_instruction = ifid.instr;
    assign if_immediate   = ifid.imm;
    assign if_pc          = ifid.pc;
    assign if_pc_next     = ifid.pc_next;
    assign if_valid       = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-by-cycle vector table walking boot, two-word
// assembly, stalls, clears, redirects and PC wrap, then a mid-run reset sequence.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        pc_write, clear_instruction, jump_taken, pc_choose_memory;
    logic [31:0] jump_target, mem_pc;
    logic [15:0] if_instruction, if_immediate;
    logic [31:0] if_pc, if_pc_next;
    logic        if_valid;

    // 256-word memory; the top word 0xFFFFF aliases to mem[255].
    logic [15:0] mem [0:255];
    assign imem_rdata = mem[imem_addr[7:0]];

    int checks = 0;
    int failures = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc_write(pc_write), .clear_instruction(clear_instruction),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .pc_choose_memory(pc_choose_memory), .mem_pc(mem_pc),
        .if_instruction(if_instruction), .if_immediate(if_immediate),
        .if_pc(if_pc), .if_pc_next(if_pc_next), .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pw, clr, jt, pcm;
        logic [31:0] jtgt, mpc;
        logic [15:0] e_instr, e_imm;
        logic [31:0] e_pc, e_pcn;
        logic        e_vld;
        logic [19:0] e_addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic pw, clr, jt, input logic [31:0] jtgt,
                                input logic pcm, input logic [31:0] mpc,
                                input logic [15:0] ei, eimm, input logic [31:0] ep, epn,
                                input logic ev, input logic [19:0] ea);
        vec_t v;
        v.pw = pw; v.clr = clr; v.jt = jt; v.jtgt = jtgt; v.pcm = pcm; v.mpc = mpc;
        v.e_instr = ei; v.e_imm = eimm; v.e_pc = ep; v.e_pcn = epn; v.e_vld = ev; v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] ei, eimm,
                           input logic [31:0] ep, epn, input logic ev, input logic [19:0] ea);
        chk({tag, ".instr"}, {16'h0, if_instruction}, {16'h0, ei});
        chk({tag, ".imm"},   {16'h0, if_immediate},   {16'h0, eimm});
        chk({tag, ".pc"},    if_pc,                   ep);
        chk({tag, ".pcn"},   if_pc_next,              epn);
        chk({tag, ".valid"}, {31'h0, if_valid},       {31'h0, ev});
        chk({tag, ".addr"},  {12'h0, imem_addr},      {12'h0, ea});
    endtask

    localparam logic [15:0] NOP = 16'h4000;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]    = 16'h0000; mem[1]    = 16'h0010; mem[2]    = 16'h9000;
        mem[16]   = 16'h8800; mem[17]   = 16'h1234; mem[18]   = 16'h0100;
        mem[19]   = 16'h2222; mem[20]   = 16'hA000; mem[21]   = 16'h5555;
        mem[22]   = 16'hA800; mem[23]   = 16'h7777;
        mem[8'h40] = 16'h0AAA; mem[8'h80] = 16'h0CCC; mem[255] = 16'h0EEE;

        //                pw clr jt jtgt      pcm mpc          instr     imm       pc            pcn           v  addr
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h1));
        vecs.push_back(mk(1, 0, 1, 32'h40, 0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h10));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h11));
        vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h11));
        vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h11));
        vecs.push_back(mk(0, 1, 0, 32'h0,  0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h11));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'h8800, 16'h1234, 32'h10,       32'h12,       1, 20'h12));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'h0100, 16'h0,    32'h12,       32'h13,       1, 20'h13));
        vecs.push_back(mk(0, 0, 0, 32'h0,  0, 32'h0,        16'h0100, 16'h0,    32'h12,       32'h13,       1, 20'h13));
        vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h14));
        vecs.push_back(mk(1, 1, 0, 32'h0,  0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h15));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'hA000, 16'h5555, 32'h14,       32'h16,       1, 20'h16));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h17));
        vecs.push_back(mk(0, 0, 1, 32'h40, 0, 32'h0,        NOP,      16'h0,    32'h0,        32'h0,        0, 20'h40));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'h0AAA, 16'h0,    32'h40,       32'h41,       1, 20'h41));
        vecs.push_back(mk(1, 0, 1, 32'h40, 1, 32'h80,       NOP,      16'h0,    32'h0,        32'h0,        0, 20'h80));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'h0CCC, 16'h0,    32'h80,       32'h81,       1, 20'h81));
        vecs.push_back(mk(1, 0, 0, 32'h0,  1, 32'hFFFFFFFF, NOP,      16'h0,    32'h0,        32'h0,        0, 20'hFFFFF));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'h0EEE, 16'h0,    32'hFFFFFFFF, 32'h0,        1, 20'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'h0000, 16'h0,    32'h0,        32'h1,        1, 20'h1));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'h0010, 16'h0,    32'h1,        32'h2,        1, 20'h2));
        vecs.push_back(mk(1, 0, 0, 32'h0,  0, 32'h0,        16'h9000, 16'h0,    32'h2,        32'h3,        1, 20'h3));

        reset = 1'b0; pc_write = 1'b1; clear_instruction = 1'b0; jump_taken = 1'b0;
        pc_choose_memory = 1'b0; jump_target = '0; mem_pc = '0;
        repeat (2) @(posedge clk);
        #1 chk_all("reset", NOP, 16'h0, 32'h0, 32'h0, 1'b0, 20'h0);

        @(negedge clk) reset = 1'b1;
        foreach (vecs[i]) begin
            pc_write = vecs[i].pw; clear_instruction = vecs[i].clr;
            jump_taken = vecs[i].jt; jump_target = vecs[i].jtgt;
            pc_choose_memory = vecs[i].pcm; mem_pc = vecs[i].mpc;
            @(posedge clk);
            #1 chk_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_imm,
                       vecs[i].e_pc, vecs[i].e_pcn, vecs[i].e_vld, vecs[i].e_addr);
            @(negedge clk);
        end

        // Mid-run reset aborts everything, then the boot sequence repeats.
        pc_write = 1'b1; clear_instruction = 1'b0; jump_taken = 1'b0; pc_choose_memory = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1 chk_all("midreset", NOP, 16'h0, 32'h0, 32'h0, 1'b0, 20'h0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1 chk_all("reboot1", NOP, 16'h0, 32'h0, 32'h0, 1'b0, 20'h1);
        @(posedge clk);
        #1 chk_all("reboot2", NOP, 16'h0, 32'h0, 32'h0, 1'b0, 20'h10);
        @(posedge clk);
        #1 chk_all("reboot3", NOP, 16'h0, 32'h0, 32'h0, 1'b0, 20'h11);
        @(posedge clk);
        #1 chk_all("reboot4", 16'h8800, 16'h1234, 32'h10, 32'h12, 1'b1, 20'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
